// File: rtl/muldiv_unit.sv
// Iterative multiply/divide engine: radix-4 Booth products and restoring division,
// presenting hi/lo result words through a start/busy/done handshake.
module muldiv_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clock,
    input  logic             clear,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic             div_by_zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int MW        = WIDTH + 2;   // extended Booth operand width
    localparam int AW        = WIDTH + 4;   // accumulator holds +/-2M without overflow
    localparam int MUL_STEPS = WIDTH / 2 + 1;
    localparam int CW        = $clog2(WIDTH + 1);

    typedef enum logic [2:0] {IDLE, MUL_ITER, DIV_ITER, FIXUP, DONE} state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             busy_q, busy_d, done_q, done_d, dbz_q, dbz_d;
    logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d;

    logic [1:0]       op_q, op_d;
    logic             sign_a_q, sign_a_d, sign_b_q, sign_b_d;
    logic [WIDTH-1:0] a_raw_q, a_raw_d;
    logic [MW-1:0]    mcand_q, mcand_d, mr_q, mr_d;
    logic [AW-1:0]    acc_q, acc_d;
    logic             qm1_q, qm1_d;
    logic [WIDTH-1:0] rem_q, rem_d, quo_q, quo_d, dvsr_q, dvsr_d;

    logic             a_neg, b_neg;
    logic [AW-1:0]    m_ext, addend, sum;
    logic [AW+MW-1:0] shifted;
    logic [WIDTH:0]   rem_sh;
    logic             ge;
    logic [WIDTH-1:0] diff;

    // Shared datapath: one Booth step and one restoring step, evaluated every cycle.
    always_comb begin
        a_neg = ~op[0] & a[WIDTH-1];
        b_neg = ~op[0] & b[WIDTH-1];

        m_ext = {{2{mcand_q[MW-1]}}, mcand_q};
        case ({mr_q[1:0], qm1_q})
            3'b001, 3'b010: addend = m_ext;
            3'b011:         addend = m_ext << 1;
            3'b100:         addend = -(m_ext << 1);
            3'b101, 3'b110: addend = -m_ext;
            default:        addend = '0;
        endcase
        sum     = acc_q + addend;
        shifted = {{2{sum[AW-1]}}, sum, mr_q[MW-1:2]};

        rem_sh = {rem_q, quo_q[WIDTH-1]};
        ge     = rem_sh >= {1'b0, dvsr_q};
        diff   = rem_sh[WIDTH-1:0] - dvsr_q;
    end

    always_comb begin
        // NOTE: every *_d defaults to its *_q (or to an idle value) so no path can infer a latch.
        state_d  = state_q;
        cnt_d    = cnt_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        dbz_d    = dbz_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        op_d     = op_q;
        sign_a_d = sign_a_q;
        sign_b_d = sign_b_q;
        a_raw_d  = a_raw_q;
        mcand_d  = mcand_q;
        mr_d     = mr_q;
        acc_d    = acc_q;
        qm1_d    = qm1_q;
        rem_d    = rem_q;
        quo_d    = quo_q;
        dvsr_d   = dvsr_q;

        case (state_q)
            IDLE, DONE: begin
                state_d = IDLE;
                if (start) begin
                    busy_d   = 1'b1;
                    op_d     = op;
                    a_raw_d  = a;
                    sign_a_d = a_neg;
                    sign_b_d = b_neg;
                    if (!op[1]) begin
                        mcand_d = {{2{a_neg}}, a};
                        mr_d    = {{2{b_neg}}, b};
                        acc_d   = '0;
                        qm1_d   = 1'b0;
                        cnt_d   = CW'(MUL_STEPS);
                        state_d = MUL_ITER;
                    end else begin
                        quo_d  = a_neg ? -a : a;
                        dvsr_d = b_neg ? -b : b;
                        rem_d  = '0;
                        if (b == '0) begin
                            cnt_d   = CW'(1);
                            state_d = FIXUP;
                        end else begin
                            cnt_d   = CW'(WIDTH);
                            state_d = DIV_ITER;
                        end
                    end
                end
            end
            MUL_ITER: begin
                acc_d = shifted[AW+MW-1:MW];
                mr_d  = shifted[MW-1:0];
                qm1_d = mr_q[1];
                cnt_d = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) begin
                    cnt_d   = CW'(1);
                    state_d = FIXUP;
                end
            end
            DIV_ITER: begin
                rem_d = ge ? diff : rem_sh[WIDTH-1:0];
                quo_d = {quo_q[WIDTH-2:0], ge};
                cnt_d = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) begin
                    cnt_d   = CW'(1);
                    state_d = FIXUP;
                end
            end
            FIXUP: begin
                // First cycle applies signs / zero-divisor values, second registers the outputs.
                if (cnt_q != '0) begin
                    cnt_d = '0;
                    if (op_q[1] && dvsr_q == '0) begin
                        quo_d = '1;
                        rem_d = a_raw_q;
                    end else if (op_q == 2'b10) begin
                        if (sign_a_q ^ sign_b_q) quo_d = -quo_q;
                        if (sign_a_q)            rem_d = -rem_q;
                    end
                end else begin
                    state_d = DONE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    if (op_q[1]) begin
                        hi_d  = rem_q;
                        lo_d  = quo_q;
                        dbz_d = (dvsr_q == '0);
                    end else begin
                        hi_d  = {acc_q[WIDTH-3:0], mr_q[MW-1:WIDTH]};
                        lo_d  = mr_q[WIDTH-1:0];
                        dbz_d = 1'b0;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential blocks use non-blocking assignments only, so every flop samples pre-edge values.
    always_ff @(posedge clock) begin
        if (clear) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            dbz_q   <= 1'b0;
            hi_q    <= '0;
            lo_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            dbz_q   <= dbz_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
        end
    end

    // NOTE: operand/working registers are always loaded on acceptance before use, so they carry no reset.
    always_ff @(posedge clock) begin
        op_q     <= op_d;
        sign_a_q <= sign_a_d;
        sign_b_q <= sign_b_d;
        a_raw_q  <= a_raw_d;
        mcand_q  <= mcand_d;
        mr_q     <= mr_d;
        acc_q    <= acc_d;
        qm1_q    <= qm1_d;
        rem_q    <= rem_d;
        quo_q    <= quo_d;
        dvsr_q   <= dvsr_d;
    end

    assign busy        = busy_q;
    assign done        = done_q;
    assign div_by_zero = dbz_q;
    assign hi          = hi_q;
    assign lo          = lo_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Bench for muldiv_unit: directed literal cases plus randomized traffic compared every
// cycle against an arithmetic reference model with a simple latency counter.
module tb_muldiv_unit;

    localparam int W = 32;

    logic         clock = 1'b0;
    logic         clear, start;
    logic [1:0]   op;
    logic [W-1:0] a, b;
    logic         busy, done, div_by_zero;
    logic [W-1:0] hi, lo;

    int checks = 0;
    int errors = 0;
    bit cmp_en = 1'b0;

    always #5 clock = ~clock;

    muldiv_unit #(.WIDTH(W)) dut (
        .clock       (clock),
        .clear       (clear),
        .start       (start),
        .op          (op),
        .a           (a),
        .b           (b),
        .busy        (busy),
        .done        (done),
        .div_by_zero (div_by_zero),
        .hi          (hi),
        .lo          (lo)
    );

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%h, expected 0x%h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference arithmetic: returns {div_by_zero, hi, lo}.
    function automatic logic [2*W:0] ref_result(input logic [1:0] o, input logic [W-1:0] x,
                                                 input logic [W-1:0] y);
        longint       sx, sy;
        logic [63:0]  u, q, r;
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        case (o)
            2'b00: begin
                u = 64'(sx * sy);
                return {1'b0, u};
            end
            2'b01: begin
                u = {32'b0, x} * {32'b0, y};
                return {1'b0, u};
            end
            default: begin
                if (y == '0) return {1'b1, x, {W{1'b1}}};
                if (o == 2'b10) begin
                    q = 64'(sx / sy);
                    r = 64'(sx % sy);
                    return {1'b0, r[W-1:0], q[W-1:0]};
                end
                return {1'b0, x % y, x / y};
            end
        endcase
    endfunction

    function automatic int ref_latency(input logic [1:0] o, input logic [W-1:0] y);
        if (!o[1]) return W / 2 + 3;
        return (y == '0) ? 2 : W + 2;
    endfunction

    // Cycle-level reference: an accepted op completes exactly its latency later.
    logic         m_busy, m_done, m_dbz;
    logic [W-1:0] m_hi, m_lo;
    logic [2*W:0] m_res;
    int           m_left;

    always @(posedge clock) begin
        if (clear) begin
            m_busy <= 1'b0;
            m_done <= 1'b0;
            m_dbz  <= 1'b0;
            m_hi   <= '0;
            m_lo   <= '0;
            m_left <= 0;
        end else begin
            m_done <= 1'b0;
            if (m_busy) begin
                m_left <= m_left - 1;
                if (m_left == 1) begin
                    m_busy <= 1'b0;
                    m_done <= 1'b1;
                    {m_dbz, m_hi, m_lo} <= m_res;
                end
            end else if (start) begin
                m_busy <= 1'b1;
                m_left <= ref_latency(op, b);
                m_res  <= ref_result(op, a, b);
            end
        end
    end

    always @(negedge clock) begin
        if (cmp_en) begin
            check("busy", W'(busy), W'(m_busy));
            check("done", W'(done), W'(m_done));
            check("div_by_zero", W'(div_by_zero), W'(m_dbz));
            check("hi", hi, m_hi);
            check("lo", lo, m_lo);
        end
    end

    // Issue one op; optionally pulse a stray start 'inject' cycles in. Returns edges until done.
    task automatic run_op(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                          input int inject, output int lat);
        @(negedge clock);
        start = 1'b1; op = o; a = x; b = y;
        @(posedge clock); #1;
        start = 1'b0; op = 2'($urandom); a = $urandom; b = $urandom;
        lat = 0;
        while (done !== 1'b1 && lat < 200) begin
            if (lat == inject) begin
                start = 1'b1; op = 2'($urandom); a = $urandom; b = $urandom;
            end
            @(posedge clock); #1;
            start = 1'b0;
            lat++;
        end
        if (done !== 1'b1) check("done_timeout", W'(done), 32'd1);
    endtask

    function automatic logic [W-1:0] pick_operand();
        case ($urandom_range(0, 7))
            0:       return '0;
            1:       return 32'h8000_0000;
            2:       return '1;
            3:       return 32'd1;
            default: return $urandom;
        endcase
    endfunction

    initial begin
        int lat;
        int seen;
        clear = 1'b1; start = 1'b0; op = '0; a = '0; b = '0;
        repeat (2) @(posedge clock);
        #1 cmp_en = 1'b1;
        check("rst_busy", W'(busy), 32'd0);
        check("rst_done", W'(done), 32'd0);
        check("rst_dbz", W'(div_by_zero), 32'd0);
        check("rst_hi", hi, 32'd0);
        check("rst_lo", lo, 32'd0);
        @(negedge clock) clear = 1'b0;

        run_op(2'b00, 32'd21, 32'hFFFF_FFFD, -1, lat);
        check("mul_lat", W'(lat), 32'd19);
        check("mul_hi", hi, 32'hFFFF_FFFF);
        check("mul_lo", lo, 32'hFFFF_FFC1);
        check("mul_dbz", W'(div_by_zero), 32'd0);

        run_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, -1, lat);
        check("mulu_hi", hi, 32'hFFFF_FFFE);
        check("mulu_lo", lo, 32'h0000_0001);
        run_op(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, -1, lat);
        check("muls_hi", hi, 32'h0);
        check("muls_lo", lo, 32'h1);

        run_op(2'b10, 32'hFFFF_FFF9, 32'd2, -1, lat);
        check("div_lat", W'(lat), 32'd34);
        check("div_lo", lo, 32'hFFFF_FFFD);
        check("div_hi", hi, 32'hFFFF_FFFF);
        run_op(2'b11, 32'd100, 32'd7, -1, lat);
        check("divu_lo", lo, 32'd14);
        check("divu_hi", hi, 32'd2);

        run_op(2'b10, 32'd5, 32'd0, -1, lat);
        check("dz_lat", W'(lat), 32'd2);
        check("dz_lo", lo, 32'hFFFF_FFFF);
        check("dz_hi", hi, 32'd5);
        check("dz_flag", W'(div_by_zero), 32'd1);
        run_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, -1, lat);
        check("ovf_lo", lo, 32'h8000_0000);
        check("ovf_hi", hi, 32'd0);
        check("ovf_flag", W'(div_by_zero), 32'd0);

        run_op(2'b00, 32'd6, 32'd7, 5, lat);
        check("ign_lat", W'(lat), 32'd19);
        check("ign_lo", lo, 32'd42);
        check("ign_hi", hi, 32'd0);

        // Start held through the done cycle: second op must start on the very next edge.
        @(negedge clock);
        start = 1'b1; op = 2'b11; a = 32'd100; b = 32'd7;
        @(posedge clock); #1;
        op = 2'b00; a = 32'd3; b = 32'd5;
        lat = 0;
        while (done !== 1'b1 && lat < 200) begin
            @(posedge clock); #1;
            lat++;
        end
        check("b2b_lat1", W'(lat), 32'd34);
        check("b2b_lo1", lo, 32'd14);
        @(posedge clock); #1;
        check("b2b_busy", W'(busy), 32'd1);
        check("b2b_done_low", W'(done), 32'd0);
        start = 1'b0;
        lat = 0;
        while (done !== 1'b1 && lat < 200) begin
            @(posedge clock); #1;
            lat++;
        end
        check("b2b_lat2", W'(lat), 32'd19);
        check("b2b_lo2", lo, 32'd15);
        check("b2b_hi2", hi, 32'd0);

        // Abort a divide with clear.
        @(negedge clock);
        start = 1'b1; op = 2'b10; a = 32'd1000; b = 32'd3;
        @(posedge clock); #1;
        start = 1'b0;
        repeat (9) @(posedge clock);
        @(negedge clock) clear = 1'b1;
        @(posedge clock); #1;
        check("clr_busy", W'(busy), 32'd0);
        check("clr_done", W'(done), 32'd0);
        check("clr_hi", hi, 32'd0);
        check("clr_lo", lo, 32'd0);
        @(negedge clock) clear = 1'b0;
        seen = 0;
        repeat (40) begin
            @(posedge clock); #1;
            if (done === 1'b1) seen++;
        end
        check("clr_no_done", W'(seen), 32'd0);

        run_op(2'b00, 32'd3, 32'd4, -1, lat);
        check("fresh_lat", W'(lat), 32'd19);
        check("fresh_lo", lo, 32'd12);
        check("fresh_hi", hi, 32'd0);

        // Randomized traffic: stray starts, back-to-back requests, rare clears.
        for (int i = 0; i < 4000; i++) begin
            @(negedge clock);
            clear = ($urandom_range(0, 299) == 0);
            start = ($urandom_range(0, 3) == 0);
            op    = 2'($urandom);
            a     = pick_operand();
            b     = pick_operand();
        end
        @(negedge clock);
        clear = 1'b0; start = 1'b0;
        repeat (40) @(posedge clock);
        @(negedge clock);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
